retire_unit: RTL
================

Name: retire_unit

Overview:
- In-order retirement and recovery end of the rename pipeline. Rename pushes {arch rd, new phys, old phys} at the tail; writeback marks entries complete by tag.
- Retires at most one entry per cycle from the head and returns the previous mapping's physical register to the free list.
- On a mispredicted branch reaching the head, walks the tail back one entry per cycle, restores RMT mappings and returns squashed physical registers to the free list.

Parameters:
- AL_DEPTH, 32, active-list entries (power of two).
- TAG_W, 5, log2(AL_DEPTH).
- PHYS_W, 6, physical register index width (64 phys regs).
- ARCH_W, 5, architectural register index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- disp_valid  in  1  rename presents an entry.
- disp_ready  out  1  entry accepted when disp_valid&&disp_ready.
- disp_has_dest  in  1  instruction writes a register.
- disp_arch_rd  in  ARCH_W  destination arch reg.
- disp_new_phys  in  PHYS_W  newly allocated phys reg.
- disp_old_phys  in  PHYS_W  prior RMT mapping of disp_arch_rd.
- disp_tag  out  TAG_W  slot index given to the dispatched entry (current tail).
- cmpl_valid  in  1  writeback completion.
- cmpl_tag  in  TAG_W  completing slot.
- cmpl_mispredict  in  1  completing branch was mispredicted.
- retire_valid  out  1  one entry retired this cycle.
- retire_tag  out  TAG_W  tag retired.
- free_valid  out  1  push free_phys to free list.
- free_phys  out  PHYS_W  phys reg returned.
- rmt_restore_valid  out  1  write RMT.
- rmt_restore_arch  out  ARCH_W  RMT index.
- rmt_restore_phys  out  PHYS_W  RMT value.
- squash  out  1  one-cycle pulse: flush front end and instruction queue.
- al_count  out  TAG_W+1  occupied entries.
- perf_retired  out  32  retired count (optional feature).
- perf_squashed  out  32  squashed count (optional feature).

Behaviour:
- Pointers head and tail are TAG_W+1 bits, with the MSB as the wrap bit.
- al_count = tail-head. Empty when head==tail. Full when al_count==AL_DEPTH.
- Entry fields: valid, done, mp, has_dest, arch, new_phys, old_phys.
- States: RUN, WALK.
- Reset: head=tail=0, all valid/done/mp=0, state RUN, perf counters 0.
  - All registered outputs (retire_valid, retire_tag, free_*, rmt_restore_*, squash) reset to 0.
  - disp_ready is combinational and reads 1 while in reset (empty, RUN).
  - Reset mid-WALK abandons the walk.
- disp_ready = (state==RUN) && !full && !(head commits a mispredict this cycle).
- Dispatch: write the slot at tail[TAG_W-1:0] with valid=1, done=0, mp=0; tail++. disp_tag = tail[TAG_W-1:0], combinational.
- Completion: sets done and mp on slot cmpl_tag; visible to commit the next cycle, so minimum completion-to-retire latency is 1 cycle.
  - Ignored when the slot is invalid or state==WALK.
- Commit in RUN, registered, 1-cycle output latency. When the head slot has valid && done:
  - Clear valid; head++.
  - retire_valid=1, retire_tag=head.
  - If has_dest: free_valid=1, free_phys=old_phys.
  - If mp: squash=1; enter WALK if tail != head+1, otherwise stay RUN.
- WALK, one entry per cycle:
  - Pop slot tail-1 and clear its valid; tail--.
  - If has_dest: rmt_restore_valid=1, rmt_restore_arch=arch, rmt_restore_phys=old_phys, free_valid=1, free_phys=new_phys.
  - Youngest-first order guarantees the final RMT value is the oldest mapping.
  - When tail reaches head, go to RUN the same cycle the last pop is issued.
- Simultaneous dispatch and commit in RUN are both performed, including when full: commit frees a slot but disp_ready still reads 0 that cycle.
- Pointer wrap: indices use the low TAG_W bits; the wrap bit toggles on overflow.
- free_valid is single-port: commit and walk are mutually exclusive by state, so there is no conflict.

Optional Feature:
- RETIRE_UNIT_PERF_CNT_EN defined:
  - perf_retired increments on every retire_valid.
  - perf_squashed increments on every WALK pop.
  - Both are 32-bit, wrap modulo 2^32, reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package (mips_core_pkg): al_entry_t struct, retire_state_e {RUN, WALK}, PHYS_REG_W=6, ARCH_REG_W=5 constants.
- Sub-module al_entry_array:
  - Storage only: one dispatch write port, one completion bit-set port.
  - Read ports at head and at tail-1; per-slot valid clear.
- The top holds pointers, the FSM and output registers.

Test Plan:
- Reset, then 3 dispatches (arch 1,2,3; new 32,33,34; old 1,2,3), complete tags 2,0,1 -> retire tags 0,1,2 in order on 3 consecutive cycles, free_phys 1,2,3, al_count 3->0.
- Fill 32 entries -> disp_ready=0 at count 32. Complete tag 0 -> retire; disp_ready back to 1 the following cycle. Dispatch across the wrap -> disp_tag 0, tail wrap bit toggles.
- Dispatch branch (tag 0, no dest) plus 3 younger writes (arch 5,5,6; new 40,41,42; old 5,40,6); mispredict tag 0 ->
  - Retire tag 0 with squash=1.
  - Then 3 WALK cycles restoring (6->6), (5->40), (5->5) with free_phys 42, 41, 40.
  - Then RUN with count 0.
- Completion to an invalid slot and completion during WALK -> no done bit set; later dispatch into that slot starts done=0.
- Assert rst_n mid-WALK -> all outputs 0, count 0, state RUN, disp_ready 1 after release.
- With RETIRE_UNIT_PERF_CNT_EN, run scenario 3 -> perf_retired=1, perf_squashed=3. Without the macro -> both 0.

Source files
------------

// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared active-list types and register-index widths
package mips_core_pkg;

  localparam int PHYS_REG_W = 6;
  localparam int ARCH_REG_W = 5;

  typedef enum logic {
    RUN  = 1'b0,
    WALK = 1'b1
  } retire_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  mp;
    logic                  has_dest;
    logic [ARCH_REG_W-1:0] arch;
    logic [PHYS_REG_W-1:0] new_phys;
    logic [PHYS_REG_W-1:0] old_phys;
  } al_entry_t;

endpackage

// File: rtl/retire_unit_al_entry_array.sv
// rtl/retire_unit_al_entry_array.sv - active-list storage: dispatch write, completion set, valid clear
module al_entry_array
  import mips_core_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic                  wr_has_dest,
  input  logic [ARCH_REG_W-1:0] wr_arch,
  input  logic [PHYS_REG_W-1:0] wr_new_phys,
  input  logic [PHYS_REG_W-1:0] wr_old_phys,
  input  logic                  set_en,
  input  logic [IDX_W-1:0]      set_idx,
  input  logic                  set_mp,
  input  logic                  clr_en,
  input  logic [IDX_W-1:0]      clr_idx,
  input  logic [IDX_W-1:0]      rd_head_idx,
  output al_entry_t             rd_head,
  input  logic [IDX_W-1:0]      rd_tail_idx,
  output al_entry_t             rd_tail
);

  al_entry_t mem_q [DEPTH];
  al_entry_t mem_d [DEPTH];

  // Completions only land on live slots; a fresh dispatch always starts not-done.
  always_comb begin
    mem_d = mem_q;
    if (set_en && mem_q[set_idx].valid) begin
      mem_d[set_idx].done = 1'b1;
      mem_d[set_idx].mp   = set_mp;
    end
    if (clr_en) begin
      mem_d[clr_idx].valid = 1'b0;
    end
    if (wr_en) begin
      mem_d[wr_idx] = '{valid: 1'b1, done: 1'b0, mp: 1'b0, has_dest: wr_has_dest,
                        arch: wr_arch, new_phys: wr_new_phys, old_phys: wr_old_phys};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_head = mem_q[rd_head_idx];
  assign rd_tail = mem_q[rd_tail_idx];

endmodule

// File: rtl/retire_unit.sv
// rtl/retire_unit.sv - in-order retire and mispredict walk-back for the active list
// Optional perf counters enabled by RETIRE_UNIT_PERF_CNT_EN.
module retire_unit
  import mips_core_pkg::*;
#(
  parameter int AL_DEPTH = 32,
  parameter int TAG_W    = 5,
  parameter int PHYS_W   = 6,
  parameter int ARCH_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic              disp_has_dest,
  input  logic [ARCH_W-1:0] disp_arch_rd,
  input  logic [PHYS_W-1:0] disp_new_phys,
  input  logic [PHYS_W-1:0] disp_old_phys,
  output logic [TAG_W-1:0]  disp_tag,
  input  logic              cmpl_valid,
  input  logic [TAG_W-1:0]  cmpl_tag,
  input  logic              cmpl_mispredict,
  output logic              retire_valid,
  output logic [TAG_W-1:0]  retire_tag,
  output logic              free_valid,
  output logic [PHYS_W-1:0] free_phys,
  output logic              rmt_restore_valid,
  output logic [ARCH_W-1:0] rmt_restore_arch,
  output logic [PHYS_W-1:0] rmt_restore_phys,
  output logic              squash,
  output logic [TAG_W:0]    al_count,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_squashed
);

  localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};
  localparam logic [TAG_W:0] PTR_FULL = (TAG_W+1)'(AL_DEPTH);

  retire_state_e state_q, state_d;
  logic [TAG_W:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0] count, tail_m1;
  al_entry_t head_e, tail_e;
  logic commit, commit_mp, full, disp_fire, walk_pop;

  logic              retire_valid_q, retire_valid_d;
  logic [TAG_W-1:0]  retire_tag_q, retire_tag_d;
  logic              free_valid_q, free_valid_d;
  logic [PHYS_W-1:0] free_phys_q, free_phys_d;
  logic              rmt_valid_q, rmt_valid_d;
  logic [ARCH_W-1:0] rmt_arch_q, rmt_arch_d;
  logic [PHYS_W-1:0] rmt_phys_q, rmt_phys_d;
  logic              squash_q, squash_d;

  assign count     = tail_q - head_q;
  assign tail_m1   = tail_q - PTR_ONE;
  assign full      = (count == PTR_FULL);
  assign commit    = (state_q == RUN) && head_e.valid && head_e.done;
  assign commit_mp = commit && head_e.mp;
  assign walk_pop  = (state_q == WALK);
  assign disp_ready = (state_q == RUN) && !full && !commit_mp;
  assign disp_fire = disp_valid && disp_ready;
  assign disp_tag  = tail_q[TAG_W-1:0];
  assign al_count  = count;

  al_entry_array #(.DEPTH(AL_DEPTH), .IDX_W(TAG_W)) u_array (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (disp_fire),
    .wr_idx      (tail_q[TAG_W-1:0]),
    .wr_has_dest (disp_has_dest),
    .wr_arch     (disp_arch_rd),
    .wr_new_phys (disp_new_phys),
    .wr_old_phys (disp_old_phys),
    .set_en      (cmpl_valid && (state_q == RUN)),
    .set_idx     (cmpl_tag),
    .set_mp      (cmpl_mispredict),
    .clr_en      (commit || walk_pop),
    .clr_idx     (walk_pop ? tail_m1[TAG_W-1:0] : head_q[TAG_W-1:0]),
    .rd_head_idx (head_q[TAG_W-1:0]),
    .rd_head     (head_e),
    .rd_tail_idx (tail_m1[TAG_W-1:0]),
    .rd_tail     (tail_e)
  );

  logic unused_fields;
  assign unused_fields = ^{head_e.new_phys, head_e.arch, tail_e.valid, tail_e.done, tail_e.mp};

  always_comb begin
    state_d        = state_q;
    head_d         = head_q;
    tail_d         = tail_q;
    retire_valid_d = 1'b0;
    retire_tag_d   = '0;
    free_valid_d   = 1'b0;
    free_phys_d    = '0;
    rmt_valid_d    = 1'b0;
    rmt_arch_d     = '0;
    rmt_phys_d     = '0;
    squash_d       = 1'b0;
    if (disp_fire) begin
      tail_d = tail_q + PTR_ONE;
    end
    case (state_q)
      RUN: begin
        if (commit) begin
          head_d         = head_q + PTR_ONE;
          retire_valid_d = 1'b1;
          retire_tag_d   = head_q[TAG_W-1:0];
          if (head_e.has_dest) begin
            free_valid_d = 1'b1;
            free_phys_d  = head_e.old_phys;
          end
          // A mispredict with younger entries behind it must unwind them first.
          if (head_e.mp) begin
            squash_d = 1'b1;
            if (tail_q != head_q + PTR_ONE) begin
              state_d = WALK;
            end
          end
        end
      end
      WALK: begin
        tail_d = tail_m1;
        if (tail_e.has_dest) begin
          rmt_valid_d  = 1'b1;
          rmt_arch_d   = tail_e.arch;
          rmt_phys_d   = tail_e.old_phys;
          free_valid_d = 1'b1;
          free_phys_d  = tail_e.new_phys;
        end
        if (tail_m1 == head_q) begin
          state_d = RUN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      head_q         <= '0;
      tail_q         <= '0;
      retire_valid_q <= 1'b0;
      retire_tag_q   <= '0;
      free_valid_q   <= 1'b0;
      free_phys_q    <= '0;
      rmt_valid_q    <= 1'b0;
      rmt_arch_q     <= '0;
      rmt_phys_q     <= '0;
      squash_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      retire_valid_q <= retire_valid_d;
      retire_tag_q   <= retire_tag_d;
      free_valid_q   <= free_valid_d;
      free_phys_q    <= free_phys_d;
      rmt_valid_q    <= rmt_valid_d;
      rmt_arch_q     <= rmt_arch_d;
      rmt_phys_q     <= rmt_phys_d;
      squash_q       <= squash_d;
    end
  end

  assign retire_valid      = retire_valid_q;
  assign retire_tag        = retire_tag_q;
  assign free_valid        = free_valid_q;
  assign free_phys         = free_phys_q;
  assign rmt_restore_valid = rmt_valid_q;
  assign rmt_restore_arch  = rmt_arch_q;
  assign rmt_restore_phys  = rmt_phys_q;
  assign squash            = squash_q;

`ifdef RETIRE_UNIT_PERF_CNT_EN
  logic [31:0] perf_retired_q, perf_retired_d, perf_squashed_q, perf_squashed_d;

  always_comb begin
    perf_retired_d  = perf_retired_q + {31'b0, commit};
    perf_squashed_d = perf_squashed_q + {31'b0, walk_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired_q  <= '0;
      perf_squashed_q <= '0;
    end else begin
      perf_retired_q  <= perf_retired_d;
      perf_squashed_q <= perf_squashed_d;
    end
  end

  assign perf_retired  = perf_retired_q;
  assign perf_squashed = perf_squashed_q;
`else
  assign perf_retired  = '0;
  assign perf_squashed = '0;
`endif

endmodule
